// File: rtl/tt_ctrl_sel_sync_if.sv
// Control-pin and spine-select bundle for the synchronous mux selection controller.
// The master drives the asynchronous control pins, and the slave returns the registered spine outputs.
interface tt_ctrl_sel_sync_if #(
   parameter int SEL_W = 10
);
   logic             ctrl_sel_inc;
   logic             ctrl_sel_clr;
   logic             ctrl_sel_shift;
   logic             ctrl_sel_data;
   logic             ctrl_sel_load;
   logic             ctrl_ena;
   logic [SEL_W-1:0] sel;
   logic             ena;
   logic             busy;
   logic             err;

   modport master (
      output ctrl_sel_inc, ctrl_sel_clr, ctrl_sel_shift, ctrl_sel_data, ctrl_sel_load, ctrl_ena,
      input  sel, ena, busy, err
   );

   modport slave (
      input  ctrl_sel_inc, ctrl_sel_clr, ctrl_sel_shift, ctrl_sel_data, ctrl_sel_load, ctrl_ena,
      output sel, ena, busy, err
   );
endinterface

// File: rtl/tt_ctrl_sel_sync.sv
// Synchronous spine select controller with a break-before-make enable guard around every select change.
// A command acts SYNC_STAGES+1 cycles after its pin rises, and commands that arrive while busy wait in a one-entry slot.
module tt_ctrl_sel_sync #(
   parameter int SEL_W       = 10,
   parameter int MAX_SEL     = 2**SEL_W-1,
   parameter int GUARD_CYC   = 4,
   parameter int SYNC_STAGES = 2
) (
   input logic              clk,
   input logic              rst,
   tt_ctrl_sel_sync_if.slave bus
);
   localparam int CNT_W = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;
   localparam logic [SEL_W:0] MAX_X = (SEL_W+1)'(MAX_SEL);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_BREAK = 2'd1;
   localparam logic [1:0] ST_GUARD = 2'd2;

   localparam logic [1:0] OP_NONE = 2'd0;
   localparam logic [1:0] OP_INC  = 2'd1;
   localparam logic [1:0] OP_LOAD = 2'd2;
   localparam logic [1:0] OP_CLR  = 2'd3;

   // Pin order: inc, clr, shift, load, data, ena (bit 0 upward)
   logic [5:0]       pins;
   logic [5:0]       sync_q [SYNC_STAGES];
   logic [3:0]       prev_q;
   logic [3:0]       pulse_q;
   logic [5:0]       sync_last;
   logic [1:0]       state_q;
   logic [1:0]       op_q;
   logic [1:0]       pend_q;
   logic [CNT_W-1:0] cnt_q;
   logic [SEL_W-1:0] sel_q;
   logic [SEL_W-1:0] shadow_q;
   logic             ena_q;
   logic             busy_q;
   logic             err_q;
   logic [1:0]       cmd_op;
   logic [1:0]       take_op;

   assign pins = {bus.ctrl_ena, bus.ctrl_sel_data, bus.ctrl_sel_load,
                  bus.ctrl_sel_shift, bus.ctrl_sel_clr, bus.ctrl_sel_inc};
   assign sync_last = sync_q[SYNC_STAGES-1];

   // A held clr survives any later arrival; otherwise the newest winner replaces the slot.
   function automatic logic [1:0] merge(input logic [1:0] pend, input logic clr,
                                        input logic load, input logic inc);
      if (pend == OP_CLR || clr) return OP_CLR;
      else if (load)             return OP_LOAD;
      else if (inc)              return OP_INC;
      else                       return pend;
   endfunction

   always_comb begin
      cmd_op  = merge(OP_NONE, pulse_q[1], pulse_q[3], pulse_q[0]);
      take_op = merge(pend_q,  pulse_q[1], pulse_q[3], pulse_q[0]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
         prev_q   <= '0;
         pulse_q  <= '0;
         state_q  <= ST_IDLE;
         op_q     <= OP_NONE;
         pend_q   <= OP_NONE;
         cnt_q    <= '0;
         sel_q    <= '0;
         shadow_q <= '0;
         ena_q    <= 1'b0;
         busy_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         sync_q[0] <= pins;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         prev_q  <= sync_last[3:0];
         pulse_q <= sync_last[3:0] & ~prev_q;

         if (pulse_q[2]) shadow_q <= {shadow_q[SEL_W-2:0], sync_last[4]};

         case (state_q)
            ST_IDLE: begin
               if (cmd_op != OP_NONE) begin
                  state_q <= ST_BREAK;
                  op_q    <= cmd_op;
                  busy_q  <= 1'b1;
                  ena_q   <= 1'b0;
               end else begin
                  ena_q <= sync_last[5];
               end
            end
            ST_BREAK: begin
               state_q <= ST_GUARD;
               cnt_q   <= CNT_W'(GUARD_CYC-1);
               pend_q  <= take_op;
               case (op_q)
                  OP_INC:  sel_q <= (sel_q == MAX_X[SEL_W-1:0]) ? '0 : sel_q + 1'b1;
                  OP_CLR:  begin sel_q <= '0; err_q <= 1'b0; end
                  OP_LOAD: begin
                     if ({1'b0, shadow_q} > MAX_X) err_q <= 1'b1;
                     else                          sel_q <= shadow_q;
                  end
                  default: ;
               endcase
            end
            ST_GUARD: begin
               if (cnt_q == '0) begin
                  pend_q <= OP_NONE;
                  if (take_op != OP_NONE) begin
                     // Chain straight into the next change so ena never pulses between them
                     state_q <= ST_BREAK;
                     op_q    <= take_op;
                  end else begin
                     state_q <= ST_IDLE;
                     busy_q  <= 1'b0;
                     ena_q   <= sync_last[5];
                  end
               end else begin
                  cnt_q  <= cnt_q - 1'b1;
                  pend_q <= take_op;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.sel  = sel_q;
   assign bus.ena  = ena_q;
   assign bus.busy = busy_q;
   assign bus.err  = err_q;
endmodule

// File: tb/tb_tt_ctrl_sel_sync.sv
// Scoreboard bench: drives two controllers with the same pins, one with full range and one with MAX_SEL=600.
// Expected select/err outcomes are queued per command and compared once the controller goes idle.
module tb_tt_ctrl_sel_sync;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   tt_ctrl_sel_sync_if #(.SEL_W(10)) bus_a ();
   tt_ctrl_sel_sync_if #(.SEL_W(10)) bus_b ();

   assign bus_b.ctrl_sel_inc   = bus_a.ctrl_sel_inc;
   assign bus_b.ctrl_sel_clr   = bus_a.ctrl_sel_clr;
   assign bus_b.ctrl_sel_shift = bus_a.ctrl_sel_shift;
   assign bus_b.ctrl_sel_data  = bus_a.ctrl_sel_data;
   assign bus_b.ctrl_sel_load  = bus_a.ctrl_sel_load;
   assign bus_b.ctrl_ena       = bus_a.ctrl_ena;

   tt_ctrl_sel_sync #(.SEL_W(10)) u_dut_a (.clk(clk), .rst(rst), .bus(bus_a));
   tt_ctrl_sel_sync #(.SEL_W(10), .MAX_SEL(600)) u_dut_b (.clk(clk), .rst(rst), .bus(bus_b));

   typedef struct {
      logic [9:0] sel_a;
      logic       err_a;
      logic [9:0] sel_b;
      logic       err_b;
   } exp_t;

   exp_t       sb[$];
   int         n_tests = 0;
   int         n_fail  = 0;
   logic [9:0] m_sel_a, m_sel_b, m_shadow;
   logic       m_err_a, m_err_b;
   int         low_cnt;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // op: 1 inc, 2 load, 3 clr; returns {err, sel}
   function automatic logic [10:0] model_op(input logic [1:0] op, input logic [9:0] sel,
                                            input logic err, input logic [9:0] sh, input int max);
      case (op)
         2'd1:    return {err, (int'(sel) == max) ? 10'd0 : sel + 10'd1};
         2'd2:    return (int'(sh) > max) ? {1'b1, sel} : {err, sh};
         2'd3:    return {1'b0, 10'd0};
         default: return {err, sel};
      endcase
   endfunction

   task automatic model_cmd(input logic [1:0] op);
      {m_err_a, m_sel_a} = model_op(op, m_sel_a, m_err_a, m_shadow, 1023);
      {m_err_b, m_sel_b} = model_op(op, m_sel_b, m_err_b, m_shadow, 600);
   endtask

   task automatic push_exp();
      exp_t e;
      e.sel_a = m_sel_a; e.err_a = m_err_a; e.sel_b = m_sel_b; e.err_b = m_err_b;
      sb.push_back(e);
   endtask

   task automatic wait_done(input string tag);
      exp_t e;
      int   k = 0;
      while (bus_a.busy && k < 60) begin
         tick(1);
         k++;
      end
      check({tag, ".idle"}, {31'd0, bus_a.busy}, 32'd0);
      if (sb.size() == 0) begin
         check({tag, ".sb_empty"}, 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         check({tag, ".sel_a"}, {22'd0, bus_a.sel}, {22'd0, e.sel_a});
         check({tag, ".err_a"}, {31'd0, bus_a.err}, {31'd0, e.err_a});
         check({tag, ".sel_b"}, {22'd0, bus_b.sel}, {22'd0, e.sel_b});
         check({tag, ".err_b"}, {31'd0, bus_b.err}, {31'd0, e.err_b});
      end
   endtask

   task automatic cmd(input logic inc, input logic clr, input logic load, input string tag);
      logic [1:0] op;
      op = clr ? 2'd3 : load ? 2'd2 : 2'd1;
      model_cmd(op);
      push_exp();
      bus_a.ctrl_sel_inc  = inc;
      bus_a.ctrl_sel_clr  = clr;
      bus_a.ctrl_sel_load = load;
      tick(4);
      bus_a.ctrl_sel_inc  = 1'b0;
      bus_a.ctrl_sel_clr  = 1'b0;
      bus_a.ctrl_sel_load = 1'b0;
      wait_done(tag);
   endtask

   task automatic shift_word(input logic [9:0] v);
      for (int i = 9; i >= 0; i--) begin
         bus_a.ctrl_sel_data = v[i];
         tick(2);
         bus_a.ctrl_sel_shift = 1'b1;
         tick(3);
         bus_a.ctrl_sel_shift = 1'b0;
         tick(2);
         m_shadow = {m_shadow[8:0], v[i]};
      end
   endtask

   initial begin
      bus_a.ctrl_sel_inc   = 1'b0;
      bus_a.ctrl_sel_clr   = 1'b0;
      bus_a.ctrl_sel_shift = 1'b0;
      bus_a.ctrl_sel_data  = 1'b0;
      bus_a.ctrl_sel_load  = 1'b0;
      bus_a.ctrl_ena       = 1'b0;
      m_sel_a = '0; m_sel_b = '0; m_shadow = '0; m_err_a = 1'b0; m_err_b = 1'b0;
      rst = 1'b1;
      tick(3);
      rst = 1'b0;
      tick(1);
      check("rst.sel", {22'd0, bus_a.sel}, 32'd0);
      check("rst.ena", {31'd0, bus_a.ena}, 32'd0);
      check("rst.busy", {31'd0, bus_a.busy}, 32'd0);
      check("rst.err", {31'd0, bus_a.err}, 32'd0);
      check("rst.sel_b", {22'd0, bus_b.sel}, 32'd0);

      // Enable follows the pin three cycles later without raising busy
      bus_a.ctrl_ena = 1'b1;
      tick(2);
      check("ena.early", {31'd0, bus_a.ena}, 32'd0);
      tick(1);
      check("ena.lat3", {31'd0, bus_a.ena}, 32'd1);
      check("ena.busy", {31'd0, bus_a.busy}, 32'd0);

      shift_word(10'd5);
      cmd(1'b0, 1'b0, 1'b1, "load5");

      // Cycle-accurate break-before-make around an increment
      model_cmd(2'd1);
      push_exp();
      bus_a.ctrl_sel_inc = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         tick(1);
         if (k == 4) bus_a.ctrl_sel_inc = 1'b0;
         if (k <= 3) check("inc.ena_pre", {31'd0, bus_a.ena}, 32'd1);
         if (k == 4) check("inc.sel_old", {22'd0, bus_a.sel}, 32'd5);
         if (k == 5) check("inc.sel_new", {22'd0, bus_a.sel}, 32'd6);
         if (k >= 4 && k <= 8) begin
            check("inc.ena_low", {31'd0, bus_a.ena}, 32'd0);
            check("inc.busy_hi", {31'd0, bus_a.busy}, 32'd1);
         end
         if (k == 9) begin
            check("inc.ena_back", {31'd0, bus_a.ena}, 32'd1);
            check("inc.busy_lo", {31'd0, bus_a.busy}, 32'd0);
         end
      end
      wait_done("inc5");

      shift_word(10'h3FF);
      cmd(1'b0, 1'b0, 1'b1, "load1023");
      cmd(1'b1, 1'b0, 1'b0, "wrap");
      shift_word(10'h2A5);
      cmd(1'b0, 1'b0, 1'b1, "load677");
      cmd(1'b0, 1'b1, 1'b0, "clr");

      shift_word(10'd7);
      cmd(1'b0, 1'b0, 1'b1, "load7");

      // inc+clr together, then an inc arriving during the guard chains on
      model_cmd(2'd3);
      model_cmd(2'd1);
      push_exp();
      low_cnt = 0;
      bus_a.ctrl_sel_inc = 1'b1;
      bus_a.ctrl_sel_clr = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         tick(1);
         if (bus_a.ena == 1'b0) low_cnt++;
         if (k == 2) begin bus_a.ctrl_sel_inc = 1'b0; bus_a.ctrl_sel_clr = 1'b0; end
         if (k == 4) bus_a.ctrl_sel_inc = 1'b1;
         if (k == 6) bus_a.ctrl_sel_inc = 1'b0;
      end
      check("chain.low_cycles", low_cnt, 32'd10);
      wait_done("chain");

      // Pending clr must not be displaced by a later inc
      model_cmd(2'd1);
      model_cmd(2'd3);
      push_exp();
      bus_a.ctrl_sel_inc = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         tick(1);
         if (k == 2) bus_a.ctrl_sel_inc = 1'b0;
         if (k == 3) bus_a.ctrl_sel_clr = 1'b1;
         if (k == 5) begin bus_a.ctrl_sel_clr = 1'b0; bus_a.ctrl_sel_inc = 1'b1; end
         if (k == 7) bus_a.ctrl_sel_inc = 1'b0;
      end
      wait_done("clr_keep");

      // Reset in the guard period drops the pending load
      shift_word(10'd9);
      cmd(1'b0, 1'b0, 1'b1, "load9");
      bus_a.ctrl_sel_inc = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         tick(1);
         if (k == 2) begin bus_a.ctrl_sel_inc = 1'b0; bus_a.ctrl_sel_load = 1'b1; end
         if (k == 4) bus_a.ctrl_sel_load = 1'b0;
         if (k == 5) begin
            check("rst_mid.sel_pre", {22'd0, bus_a.sel}, 32'd10);
            check("rst_mid.sel_pre_b", {22'd0, bus_b.sel}, 32'd10);
         end
         if (k == 6) begin rst = 1'b1; bus_a.ctrl_ena = 1'b0; end
         if (k == 7) begin
            rst = 1'b0;
            check("rst_mid.sel", {22'd0, bus_a.sel}, 32'd0);
            check("rst_mid.ena", {31'd0, bus_a.ena}, 32'd0);
            check("rst_mid.busy", {31'd0, bus_a.busy}, 32'd0);
         end
      end
      m_sel_a = '0; m_sel_b = '0; m_shadow = '0; m_err_a = 1'b0; m_err_b = 1'b0;
      tick(20);
      check("rst_after.sel", {22'd0, bus_a.sel}, 32'd0);
      check("rst_after.sel_b", {22'd0, bus_b.sel}, 32'd0);
      check("rst_after.busy", {31'd0, bus_a.busy}, 32'd0);
      check("rst_after.ena", {31'd0, bus_a.ena}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/tt_ctrl_sel_sync.md
Name: tt_ctrl_sel_sync

Overview:
- Next-generation mux selection controller that replaces the ripple-counter select chain with a fully synchronous design.
- Drives the spine select bus and the enable line for the selected user design.
- Adds parametrised select width, serial direct-address load, a clear command, and a break-before-make enable guard around every select change.
- Sits between the control pins and the spine driver buffers.

Parameters:
- SEL_W, 10, width of select bus.
- MAX_SEL, 2**SEL_W-1, highest valid select value; increment wraps past it.
- GUARD_CYC, 4, cycles ena is held low after sel changes (>=1).
- SYNC_STAGES, 2, flip-flop synchroniser depth on each control pin (>=2).

Ports:
- clk  in  1  block clock.
- rst  in  1  synchronous reset, active-high.
- ctrl_sel_inc  in  1  async pin; rising edge = increment select.
- ctrl_sel_clr  in  1  async pin; rising edge = select := 0, clear err.
- ctrl_sel_shift  in  1  async pin; rising edge shifts ctrl_sel_data into the shadow register.
- ctrl_sel_data  in  1  async pin; serial address bit, MSB first.
- ctrl_sel_load  in  1  async pin; rising edge = select := shadow.
- ctrl_ena  in  1  async pin; requested enable level.
- sel  out  SEL_W  registered select to the spine.
- ena  out  1  registered enable to the spine.
- busy  out  1  high while a select change or guard period is in progress.
- err  out  1  sticky; a load was attempted with shadow > MAX_SEL.

Behaviour:
- Reset: rst sampled on the clk edge. sel=0, ena=0, busy=0, err=0, shadow=0, pending=NONE, state=IDLE, all synchroniser and edge-detect flops=0. Reset mid-operation aborts any sequence; no further output change until a new command.
- Input path: every async pin passes through SYNC_STAGES flops. Edge detect compares the synchronised value with its previous value. The command pulse (cmd) appears SYNC_STAGES+1 cycles after the pin rises. Level and falling edges are ignored.
- Shift: on a shift pulse, shadow <= {shadow[SEL_W-2:0], data_sync}. data_sync is taken in the same cycle as the shift pulse. Shift is accepted in any state and does not affect sel, ena or busy.
- Command priority within a cycle: clr > load > inc. Only the winner is acted on.
- FSM states:
  - IDLE: ena = ctrl_ena_sync, registered one cycle later. A command in cycle T moves to BREAK; busy=1 from T+1.
  - BREAK: one cycle. ena=0 from T+1; sel still holds its old value. The sel update is computed here:
    - inc: sel+1, with MAX_SEL -> 0.
    - clr: 0, and err <= 0.
    - load: shadow if shadow <= MAX_SEL. Otherwise sel is unchanged and err <= 1.
    - New sel is visible at T+2. Next state is GUARD.
  - GUARD: ena=0 for GUARD_CYC cycles, counting from T+2. Then back to IDLE. ena follows ctrl_ena_sync from T+2+GUARD_CYC; busy=0 from the same cycle.
- Commands arriving in BREAK or GUARD are stored in a one-entry pending slot:
  - A later command overwrites the slot, except that a pending clr is never overwritten.
  - On return to IDLE, a non-empty pending entry is taken as a command in that same cycle, so ena stays 0 and busy stays 1.
- ena is never high in the cycle sel changes, nor in the cycle before it. This break-before-make rule is mandatory.
- ctrl_ena changes while in IDLE propagate with SYNC_STAGES+1 cycles of latency and do not set busy.

Test Plan:
- Reset, then ctrl_ena=1 -> sel=0; ena=1 exactly 3 cycles after the pin rises; busy=0, err=0.
- With sel=5 and ena=1, pulse inc -> ena=0 at T+1, sel=6 at T+2, ena=1 at T+6, busy high T+1..T+5.
- With sel=1023 (SEL_W=10), inc -> sel=0, no err. Shift in 10'h2A5 MSB first then load -> sel=677. With MAX_SEL=600, load of 677 -> sel unchanged, err=1; a later clr -> sel=0, err=0.
- inc and clr edges in the same cycle from sel=7 -> sel=0. A second inc during GUARD -> executes right after; sel=1, ena stays low without a gap, total low time 2*(GUARD_CYC+1) cycles.
- clr pending during GUARD, followed by inc -> clr is retained, final sel=0.
- rst asserted during GUARD with sel=9 -> next cycle sel=0, ena=0, busy=0, pending cleared; no deferred command executes afterwards.
